// File: rtl/uart_arb_pkg.sv
// Shared types for the two-source UART transmit arbiter.
// FSM state encoding and one-hot grant constants.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_BUSY,
    WAIT_DONE
  } arb_state_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_0    = 2'b01;
  localparam logic [1:0] GRANT_1    = 2'b10;

endpackage

// File: rtl/uart_tx_arbiter_fifo.sv
// byte_fifo: small circular byte queue with registered count.
// Head byte is shown combinationally; push and pop may coincide.
module byte_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [DW-1:0]          push_data,
  input  logic                   pop,
  output logic [DW-1:0]          pop_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push;
  logic          do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == FULL_CNT);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;

  // Next pointer/count/storage; pointers wrap naturally at DEPTH.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
  end

  // Storage and pointers; reset empties the queue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: two byte FIFOs sharing one UART transmitter.
// Define UART_ARB_RR_EN for round-robin; default is fixed priority.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0_valid,
  input  logic [DW-1:0] req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [DW-1:0] req1_data,
  output logic          req1_ready,
  output logic          tx_start,
  output logic [DW-1:0] tx_data,
  input  logic          tx_busy,
  output logic [1:0]    grant
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  arb_state_t    state_q, state_d;
  logic [DW-1:0] tx_data_q, tx_data_d;
  logic [1:0]    grant_q, grant_d;

  logic [DW-1:0] head0, head1;
  logic [CW-1:0] cnt0, cnt1;
  logic          empty0, empty1;
  logic          full0, full1;
  logic          push0, push1;
  logic          pop0, pop1;
  logic          any_req;
  logic          pick1;

  // Ready comes from the registered count, so a same-cycle pop
  // never opens a slot early.
  assign req0_ready = (cnt0 != FULL_CNT);
  assign req1_ready = (cnt1 != FULL_CNT);
  assign push0      = req0_valid & ~full0;
  assign push1      = req1_valid & ~full1;
  assign any_req    = ~empty0 | ~empty1;

  byte_fifo #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_fifo0 (
    .clk       (clk),
    .reset     (reset),
    .push      (push0),
    .push_data (req0_data),
    .pop       (pop0),
    .pop_data  (head0),
    .count     (cnt0),
    .empty     (empty0),
    .full      (full0)
  );

  byte_fifo #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_fifo1 (
    .clk       (clk),
    .reset     (reset),
    .push      (push1),
    .push_data (req1_data),
    .pop       (pop1),
    .pop_data  (head1),
    .count     (cnt1),
    .empty     (empty1),
    .full      (full1)
  );

`ifdef UART_ARB_RR_EN
  logic last_q, last_d;

  // Source 1 wins alone, or when both wait and 0 won last time.
  always_comb begin
    pick1 = ~empty1 & (empty0 | ~last_q);
  end

  // Remember the most recent winner; reset favours source 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`else
  // Fixed priority: source 1 only wins when source 0 is empty.
  always_comb begin
    pick1 = ~empty1 & empty0;
  end
`endif

  // State and frame registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      tx_data_q <= '0;
      grant_q   <= GRANT_NONE;
    end else begin
      state_q   <= state_d;
      tx_data_q <= tx_data_d;
      grant_q   <= grant_d;
    end
  end

  // Next-state: one frame at a time, fully drained before regrant.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (any_req) state_d = START;
      START:     state_d = WAIT_BUSY;
      WAIT_BUSY: if (tx_busy) state_d = WAIT_DONE;
      WAIT_DONE: if (!tx_busy) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Outputs: pop the winner in IDLE, hold byte/grant until done.
  always_comb begin
    pop0      = 1'b0;
    pop1      = 1'b0;
    tx_data_d = tx_data_q;
    grant_d   = grant_q;
    tx_start  = (state_q == START);
`ifdef UART_ARB_RR_EN
    last_d    = last_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          unique case (1'b1)
            pick1: begin
              pop1      = 1'b1;
              tx_data_d = head1;
              grant_d   = GRANT_1;
`ifdef UART_ARB_RR_EN
              last_d    = 1'b1;
`endif
            end
            default: begin
              pop0      = 1'b1;
              tx_data_d = head0;
              grant_d   = GRANT_0;
`ifdef UART_ARB_RR_EN
              last_d    = 1'b0;
`endif
            end
          endcase
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) grant_d = GRANT_NONE;
      end
      default: begin
      end
    endcase
  end

  assign tx_data = tx_data_q;
  assign grant   = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter.
// Expected frames are queued at stimulus time; a monitor checks starts.
module tb_uart_tx_arbiter;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] grant;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req0_valid = 1'b0;
  logic [7:0] req0_data = '0;
  logic       req0_ready;
  logic       req1_valid = 1'b0;
  logic [7:0] req1_data = '0;
  logic       req1_ready;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic [1:0] grant;

  logic force_busy = 1'b0;
  logic model_busy = 1'b0;
  bit   model_en = 1'b0;
  int   busy_len = 6;

  int   n_checks = 0;
  int   n_fail = 0;
  int   n_starts = 0;
  exp_t sb[$];
  exp_t e;
  bit         prev_start = 1'b0;
  logic [7:0] held_data = '0;
  logic [1:0] held_grant = '0;

  assign tx_busy = force_busy | model_busy;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .DEPTH (4),
    .DW    (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .tx_busy    (tx_busy),
    .grant      (grant)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_tx(input logic [7:0] d, input logic [1:0] g);
    sb.push_back(exp_t'({d, g}));
  endtask

  // Monitor: every start pops the scoreboard; frame fields must hold.
  always @(negedge clk) begin
    if (reset && tx_start) begin
      n_starts++;
      check("start_one_cycle", 32'(prev_start), 0);
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_start: got data %0h expected no frame",
                 tx_data);
      end else begin
        e = sb.pop_front();
        check("tx_data", 32'(tx_data), 32'(e.data));
        check("grant", 32'(grant), 32'(e.grant));
      end
      held_data  = tx_data;
      held_grant = grant;
    end else if (reset && grant != 2'b00) begin
      check("tx_data_hold", 32'(tx_data), 32'(held_data));
      check("grant_hold", 32'(grant), 32'(held_grant));
    end
    prev_start = tx_start;
  end

  // Transmitter model: busy one cycle after start, for busy_len cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (model_en && tx_start) begin
        @(negedge clk);
        model_busy = 1'b1;
        repeat (busy_len) @(negedge clk);
        model_busy = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input int sel, input logic [7:0] d);
    if (sel == 0) begin
      req0_valid = 1'b1;
      req0_data  = d;
    end else begin
      req1_valid = 1'b1;
      req1_data  = d;
    end
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic push_both(input logic [7:0] a, input logic [7:0] b);
    req0_valid = 1'b1;
    req0_data  = a;
    req1_valid = 1'b1;
    req1_data  = b;
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic wait_busy(input string name, input logic v,
                           input int max);
    int i = 0;
    while (tx_busy !== v && i < max) begin
      @(negedge clk);
      #1;
      i++;
    end
    n_checks++;
    if (tx_busy !== v) begin
      n_fail++;
      $display("FAIL %s: got busy %0b expected %0b", name, tx_busy, v);
    end
  endtask

  task automatic wait_idle(input string name, input int max);
    int i = 0;
    while ((sb.size() != 0 || grant != 2'b00 || tx_busy) && i < max) begin
      @(negedge clk);
      i++;
    end
    n_checks++;
    if (i >= max) begin
      n_fail++;
      $display("FAIL %s: got %0d frames pending expected 0",
               name, sb.size());
    end
    tick(2);
  endtask

  // Start a frame and park it in WAIT_DONE with busy held high.
  task automatic hold_frame(input int sel, input logic [7:0] d);
    model_en   = 1'b0;
    force_busy = 1'b1;
    expect_tx(d, (sel == 0) ? 2'b01 : 2'b10);
    push(sel, d);
    tick(3);
  endtask

  task automatic release_frame();
    force_busy = 1'b0;
    model_en   = 1'b1;
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_req0_ready"}, 32'(req0_ready), 1);
    check({tag, "_req1_ready"}, 32'(req1_ready), 1);
    check({tag, "_tx_start"}, 32'(tx_start), 0);
    check({tag, "_tx_data"}, 32'(tx_data), 0);
    check({tag, "_grant"}, 32'(grant), 0);
  endtask

  initial begin
    int s;
    tick(3);
    check_reset_outs("rst");
    reset = 1'b1;
    tick(2);

    // Single byte: latency and grant clear after frame.
    busy_len = 100;
    model_en = 1'b1;
    expect_tx(8'h41, 2'b01);
    push(0, 8'h41);
    check("lat_k1", 32'(tx_start), 0);
    tick();
    check("lat_k2", 32'(tx_start), 1);
    tick();
    check("lat_k3", 32'(tx_start), 0);
    wait_busy("busy_rise", 1'b1, 5);
    check("grant_inflight", 32'(grant), 1);
    wait_busy("busy_fall", 1'b0, 200);
    tick();
    check("grant_cleared", 32'(grant), 0);
    wait_idle("single", 300);

    // FIFO 1 fills while a frame is parked; busy high at START end.
    busy_len = 6;
    hold_frame(0, 8'h55);
    s = n_starts;
    for (int i = 0; i < 4; i++) begin
      expect_tx(8'h10 + 8'(i), 2'b10);
      push(1, 8'h10 + 8'(i));
    end
    check("full_ready", 32'(req1_ready), 0);
    req1_valid = 1'b1;
    req1_data  = 8'h14;
    for (int i = 0; i < 3; i++) begin
      check("full_hold_ready", 32'(req1_ready), 0);
      tick();
    end
    req1_valid = 1'b0;
    check("no_restart", 32'(n_starts), 32'(s));
    release_frame();
    wait_idle("fill", 500);

    // Arbitration order with both FIFOs holding two bytes.
    hold_frame(1, 8'hC3);
    push_both(8'hA0, 8'hB0);
    push_both(8'hA1, 8'hB1);
`ifdef UART_ARB_RR_EN
    expect_tx(8'hA0, 2'b01);
    expect_tx(8'hB0, 2'b10);
    expect_tx(8'hA1, 2'b01);
    expect_tx(8'hB1, 2'b10);
`else
    expect_tx(8'hA0, 2'b01);
    expect_tx(8'hA1, 2'b01);
    expect_tx(8'hB0, 2'b10);
    expect_tx(8'hB1, 2'b10);
`endif
    release_frame();
    wait_idle("arb", 500);

    // Push and pop together on FIFO 0 at count 2.
    hold_frame(1, 8'hC4);
    expect_tx(8'h20, 2'b01);
    expect_tx(8'h21, 2'b01);
    expect_tx(8'h22, 2'b01);
    push(0, 8'h20);
    push(0, 8'h21);
    release_frame();
    tick();
    check("pp_ready", 32'(req0_ready), 1);
    push(0, 8'h22);
    check("pp_count", 32'(dut.u_fifo0.count_q), 2);
    wait_idle("pushpop", 500);

    // Reset in WAIT_DONE with two bytes queued per FIFO.
    hold_frame(0, 8'h66);
    push_both(8'h70, 8'h80);
    push_both(8'h71, 8'h81);
    reset = 1'b0;
    tick();
    check_reset_outs("midrst");
    force_busy = 1'b0;
    reset = 1'b1;
    model_en = 1'b1;
    s = n_starts;
    tick(12);
    check("rst_no_start", 32'(n_starts), 32'(s));
    check("rst_sb_empty", 32'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one UART transmitter between two byte sources: the keyboard bytes received on `RsRx`, and the local switch/button sends. Each source has its own small FIFO. A grant FSM selects a source, pops one byte, starts the transmitter, and waits for the whole frame to finish before it grants again. The block sits between the two requesters and the `uart` transmit side that drives `JA1`.

## Interface
Parameters:
- `DEPTH`, 4: per-requester FIFO depth in bytes; must be a power of 2 and at least 2.
- `DW`, 8: data width.

Ports:
- `clk` in 1: system clock, 100 MHz.
- `reset` in 1: asynchronous, active-low reset.
- `req0_valid` in 1: requester 0 (keyboard path) offers a byte.
- `req0_data` in `DW`: requester 0 byte.
- `req0_ready` out 1: FIFO 0 can accept a byte.
- `req1_valid` in 1: requester 1 (switch path) offers a byte.
- `req1_data` in `DW`: requester 1 byte.
- `req1_ready` out 1: FIFO 1 can accept a byte.
- `tx_start` out 1: one-cycle start pulse to the transmitter.
- `tx_data` out `DW`: byte to transmit; held stable from `tx_start` until the frame completes.
- `tx_busy` in 1: transmitter is sending a frame.
- `grant` out 2: one-hot source of the frame in flight; `00` when idle.

## Operation
- A push happens on the rising edge where `reqN_valid & reqN_ready`.
- `reqN_ready = (countN != DEPTH)`, taken from registered count only.
  - A pop in the same cycle does not raise `ready` for that cycle.
- A push and a pop on the same FIFO in the same cycle leave the count unchanged; the data order is preserved.
- FSM states: `IDLE`, `START`, `WAIT_BUSY`, `WAIT_DONE`.
  - `IDLE`: if either FIFO is non-empty, select a winner, pop its head into `tx_data`, set `grant`, and go to `START`. Otherwise stay.
  - `START`: `tx_start=1` for exactly one cycle, then go to `WAIT_BUSY`.
  - `WAIT_BUSY`: stay until `tx_busy=1`, then go to `WAIT_DONE`. If `tx_busy` is already 1 on entry, move to `WAIT_DONE` on the next edge.
  - `WAIT_DONE`: stay until `tx_busy=0`, then clear `grant` and go to `IDLE`.
- Winner selection: with both FIFOs non-empty, see Configuration. With one non-empty, that one wins.
- Counts are `$clog2(DEPTH)+1` bits wide. Read and write pointers are `$clog2(DEPTH)` bits and wrap modulo `DEPTH`.
- Reset mid-frame: all state clears immediately, both FIFOs are emptied, and queued bytes are lost. The transmitter finishes its own frame independently.

## Timing
- Reset values: `req0_ready=1`, `req1_ready=1`, `tx_start=0`, `tx_data=0`, `grant=00`, state `IDLE`.
- Latency: with the block idle and both FIFOs empty, a byte accepted at edge k is popped at edge k+1. `tx_start` is high in the cycle after edge k+1 and deasserts at edge k+2.
- Back-to-back frames: the next `tx_start` comes no sooner than 2 cycles after `tx_busy` falls.
- `tx_data` and `grant` do not change from the pop until the return to `IDLE`.

## Configuration
- `UART_ARB_RR_EN` defined: round-robin arbitration.
  - A 1-bit `last` register records the most recent winner; reset value is 1, so requester 0 wins first.
  - When both FIFOs are non-empty, the source that was not `last` wins.
- Undefined: fixed priority; requester 0 always wins when non-empty, and the `last` register is not built.

## Structure
- Shared package `uart_arb_pkg`:
  - state enum `arb_state_t` (`IDLE`, `START`, `WAIT_BUSY`, `WAIT_DONE`);
  - constants `GRANT_NONE=2'b00`, `GRANT_0=2'b01`, `GRANT_1=2'b10`.
- Sub-module `byte_fifo` (parameters `DEPTH`, `DW`; ports push/pop/data/count/empty/full), instantiated twice.
- Arbiter FSM lives in the top module.

## Test plan
- Reset with `reset=0` mid-`WAIT_DONE` and both FIFOs holding 2 bytes -> all outputs return to reset values next cycle; after release no `tx_start` occurs without new pushes.
- Single push `req0_data=8'h41`, transmitter model raises `tx_busy` 1 cycle after start and holds it for 100 cycles -> `tx_start` exactly 2 cycles after the push, `tx_data=8'h41`, `grant=01`, and `grant=00` once `tx_busy` falls.
- Push 4 bytes `8'h10..8'h13` to FIFO 1 back-to-back with `tx_busy` held high -> `req1_ready=0` after the 4th push; the 5th offer is not accepted; bytes are transmitted in order `10,11,12,13`.
- With `UART_ARB_RR_EN`, preload FIFO 0 with `A0,A1` and FIFO 1 with `B0,B1` -> transmit order `A0,B0,A1,B1`. Without the macro -> `A0,A1,B0,B1`.
- Simultaneous push and pop on FIFO 0 at count 2 -> count stays 2 and data order is intact.
- `tx_busy` already high when `START` ends -> FSM waits for the fall and issues no second `tx_start` during the frame.
